// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-serial loader that fills the 32-entry instruction memory
//
// Purpose:
//   Accepts a framed byte stream: count N, then N 16-bit words sent high byte
//   first, then an XOR checksum byte. Each completed word is written to
//   instruction memory. The CPU is held in reset for the whole session and is
//   released only after the checksum matches.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin a load session (honoured in IDLE, DONE, ERR)
//   in_valid, in_data byte source; a byte moves when in_valid && in_ready
//   in_ready          loader will take a byte this cycle
//   im_we             one-cycle instruction memory write strobe
//   im_addr, im_wdata write address and 16-bit instruction word
//   cpu_hold          keeps the CPU in reset while high
//   done, err         level status of the last session

module im_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] LP_DEPTH = 9'(DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_count_bad;
    logic               w_idle_like;

    logic [ADDR_W:0]    r_remaining;
    logic [7:0]         r_csum;
    logic [7:0]         r_high;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_err;

    assign w_accept    = in_valid & w_in_ready;
    assign w_count_bad = (in_data == 8'd0) || ({1'b0, in_data} > LP_DEPTH);
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_COUNT;
                end
            end
            S_COUNT: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_count_bad ? S_ERR : S_HI;
                end
            end
            S_HI: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = S_LO;
                end
            end
            S_LO: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = (r_remaining == (ADDR_W+1)'(1)) ? S_CHECK : S_HI;
                end
            end
            S_CHECK: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = (in_data == r_csum) ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
            r_csum      <= '0;
            r_high      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hold      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Advance after each write, except after the last word so the
            // address stays at the final written slot instead of wrapping.
            if (r_we && (r_remaining != '0)) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_idle_like) begin
                if (start) begin
                    r_hold <= 1'b1;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    r_csum <= '0;
                    r_addr <= '0;
                end
            end else if (w_accept) begin
                case (r_state)
                    S_COUNT: begin
                        if (w_count_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_remaining <= in_data[ADDR_W:0];
                            r_csum      <= r_csum ^ in_data;
                        end
                    end
                    S_HI: begin
                        r_high <= in_data;
                        r_csum <= r_csum ^ in_data;
                    end
                    S_LO: begin
                        r_csum      <= r_csum ^ in_data;
                        r_remaining <= r_remaining - 1'b1;
                        r_we        <= 1'b1;
                        r_wdata     <= {r_high, in_data};
                    end
                    S_CHECK: begin
                        if (in_data == r_csum) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready = w_in_ready;
    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign cpu_hold = r_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule
